// File: rtl/img_seq_ctrl.sv
// Image-processing flow sequencer: drives one stage enable at a time
// (recv, pad, conv, xmit) and advances on rising completion edges.
// A quiet gap separates stages. A per-stage timeout leads to ERROR.
module img_seq_ctrl #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TMO_W      = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] skip,
    input  logic       abort,
    input  logic       imrx_complete,
    input  logic       pad_complete,
    input  logic       conv_complete,
    input  logic       tx_complete,
    output logic       en_recv,
    output logic       en_pad,
    output logic       en_conv,
    output logic       en_xmit,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_stage,
    output logic [2:0] stage
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRecv  = 3'd1,
        StPad   = 3'd2,
        StConv  = 3'd3,
        StXmit  = 3'd4,
        StGap   = 3'd5,
        StDone  = 3'd6,
        StError = 3'd7
    } state_t;

    localparam logic [TMO_W-1:0] TmoMax  = '1;
    localparam logic [7:0]       GapLoad = 8'(GAP_CYCLES - 1);

    state_t           state;
    logic [3:0]       skip_q;
    logic [3:0]       en_q;
    logic [3:0]       cmp;
    logic [3:0]       cmp_prev;
    logic [3:0]       rise;
    logic [1:0]       cur_idx;
    logic [1:0]       nxt_idx;
    logic [7:0]       gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       start_pick;
    logic [2:0]       after_pick;
    logic             hit;

    // Lowest available stage: {valid, index}.
    function automatic logic [2:0] pick(input logic [3:0] avail);
        if (avail[0])      return 3'b100;
        else if (avail[1]) return 3'b101;
        else if (avail[2]) return 3'b110;
        else if (avail[3]) return 3'b111;
        else               return 3'b000;
    endfunction

    // Stages strictly after the given one.
    function automatic logic [3:0] later_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1100;
            2'd2:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic state_t stage_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return StRecv;
            2'd1:    return StPad;
            2'd2:    return StConv;
            default: return StXmit;
        endcase
    endfunction

    assign cmp        = {tx_complete, conv_complete, pad_complete, imrx_complete};
    assign rise       = cmp & ~cmp_prev;
    assign hit        = rise[cur_idx];
    assign start_pick = pick(~skip);
    assign after_pick = pick(~skip_q & later_mask(cur_idx));

    assign en_recv = en_q[0];
    assign en_pad  = en_q[1];
    assign en_conv = en_q[2];
    assign en_xmit = en_q[3];
    assign stage   = state;

    // Sequencer FSM with registered enables and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            skip_q    <= '0;
            en_q      <= '0;
            cmp_prev  <= '0;
            cur_idx   <= '0;
            nxt_idx   <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_stage <= '0;
        end else begin
            cmp_prev <= cmp;
            done     <= 1'b0;
            if (abort) begin
                state   <= StIdle;
                en_q    <= '0;
                busy    <= 1'b0;
                gap_cnt <= '0;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    StIdle, StDone, StError: begin
                        if (start) begin
                            skip_q <= skip;
                            error  <= 1'b0;
                            if (start_pick[2]) begin
                                state   <= stage_of(start_pick[1:0]);
                                cur_idx <= start_pick[1:0];
                                en_q    <= 4'b0001 << start_pick[1:0];
                                tmo_cnt <= '0;
                                busy    <= 1'b1;
                            end else begin
                                state <= StDone;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else if (state == StDone) begin
                            state <= StIdle;
                        end
                    end
                    StRecv, StPad, StConv, StXmit: begin
                        // A completion edge wins over a timeout in the same cycle.
                        if (hit) begin
                            en_q <= '0;
                            if (after_pick[2]) begin
                                state   <= StGap;
                                nxt_idx <= after_pick[1:0];
                                gap_cnt <= GapLoad;
                            end else begin
                                state <= StDone;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else if (tmo_cnt == TmoMax) begin
                            state     <= StError;
                            en_q      <= '0;
                            error     <= 1'b1;
                            err_stage <= cur_idx;
                            busy      <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    StGap: begin
                        if (gap_cnt == 8'd0) begin
                            state   <= stage_of(nxt_idx);
                            cur_idx <= nxt_idx;
                            en_q    <= 4'b0001 << nxt_idx;
                            tmo_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
